// File: rtl/text_dump_tx_if.sv
// rtl/text_dump_tx_if.sv - start/done, text RAM read port and UART transmit handshake of the screen-dump engine
interface text_dump_tx_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  Start_i;
  logic                  Busy_o;
  logic                  Done_o;
  logic [ADDR_WIDTH-1:0] RamAddr_o;
  logic [15:0]           RamData_i;
  logic                  TxStart_o;
  logic [7:0]            TxData_o;
  logic                  TxDone_i;

  modport master (
    input  Start_i, RamData_i, TxDone_i,
    output Busy_o, Done_o, RamAddr_o, TxStart_o, TxData_o
  );

  modport slave (
    output Start_i, RamData_i, TxDone_i,
    input  Busy_o, Done_o, RamAddr_o, TxStart_o, TxData_o
  );
endinterface

// File: rtl/text_dump_tx.sv
// rtl/text_dump_tx.sv - text RAM screen dump to UART; colour commands compiled in with TEXT_DUMP_COLOR_EN
module text_dump_tx #(
  parameter int         COLUMNS    = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] EOL_BYTE   = 8'h13
) (
  input logic            Clock,
  input logic            Reset,
  text_dump_tx_if.master bus
);
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLUMNS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
`ifdef TEXT_DUMP_COLOR_EN
    S_FG,
    S_BG,
`endif
    S_CHAR,
    S_EOL,
    S_FINISH
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            w_tx_done;

  // A completion pulse is only meaningful once our own start pulse has gone out.
  assign w_tx_done = bus.TxDone_i && !bus.TxStart_o;

  // Bit 7 is reserved for terminal commands, so such characters go out as '?'.
  function automatic logic [7:0] char_byte(input logic [7:0] c);
    return c[7] ? 8'h3F : c;
  endfunction

`ifdef TEXT_DUMP_COLOR_EN
  logic [15:0] r_cell;
  logic        r_fg_valid;
  logic        r_bg_valid;
  logic [2:0]  r_fg_last;
  logic [2:0]  r_bg_last;
  logic [15:0] w_cell;
  logic [2:0]  w_fg;
  logic [2:0]  w_bg;
  logic        w_fg_need;
  logic        w_bg_need;
  logic        w_unused_cell;

  // In WAIT the RAM word is used directly so the first byte can launch on the next cycle.
  assign w_cell        = (r_state == S_WAIT) ? bus.RamData_i : r_cell;
  assign w_fg          = w_cell[14:12];
  assign w_bg          = w_cell[10:8];
  assign w_fg_need     = !r_fg_valid || (w_fg != r_fg_last);
  assign w_bg_need     = !r_bg_valid || (w_bg != r_bg_last);
  assign w_unused_cell = w_cell[15] ^ w_cell[11];
`else
  logic w_unused_attr;
  assign w_unused_attr = ^bus.RamData_i[15:8];
`endif

  // Dump sequencer: each send state is entered together with its TxStart pulse and held until TxDone.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      bus.Busy_o    <= 1'b0;
      bus.Done_o    <= 1'b0;
      bus.TxStart_o <= 1'b0;
      bus.TxData_o  <= 8'h00;
      bus.RamAddr_o <= '0;
`ifdef TEXT_DUMP_COLOR_EN
      r_cell        <= '0;
      r_fg_valid    <= 1'b0;
      r_bg_valid    <= 1'b0;
      r_fg_last     <= '0;
      r_bg_last     <= '0;
`endif
    end else begin
      bus.TxStart_o <= 1'b0;
      bus.Done_o    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Start_i) begin
            bus.Busy_o    <= 1'b1;
            bus.RamAddr_o <= '0;
            r_col         <= '0;
            r_row         <= '0;
`ifdef TEXT_DUMP_COLOR_EN
            r_fg_valid    <= 1'b0;
            r_bg_valid    <= 1'b0;
`endif
            r_state       <= S_READ;
          end
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
`ifdef TEXT_DUMP_COLOR_EN
          r_cell <= bus.RamData_i;
          bus.TxStart_o <= 1'b1;
          if (w_fg_need) begin
            bus.TxData_o <= {1'b1, w_fg, 1'b0, 3'b000};
            r_fg_valid   <= 1'b1;
            r_fg_last    <= w_fg;
            r_state      <= S_FG;
          end else if (w_bg_need) begin
            bus.TxData_o <= {1'b1, w_bg, 1'b1, 3'b000};
            r_bg_valid   <= 1'b1;
            r_bg_last    <= w_bg;
            r_state      <= S_BG;
          end else begin
            bus.TxData_o <= char_byte(w_cell[7:0]);
            r_state      <= S_CHAR;
          end
`else
          bus.TxStart_o <= 1'b1;
          bus.TxData_o  <= char_byte(bus.RamData_i[7:0]);
          r_state       <= S_CHAR;
`endif
        end
`ifdef TEXT_DUMP_COLOR_EN
        S_FG: begin
          if (w_tx_done) begin
            bus.TxStart_o <= 1'b1;
            if (w_bg_need) begin
              bus.TxData_o <= {1'b1, w_bg, 1'b1, 3'b000};
              r_bg_valid   <= 1'b1;
              r_bg_last    <= w_bg;
              r_state      <= S_BG;
            end else begin
              bus.TxData_o <= char_byte(w_cell[7:0]);
              r_state      <= S_CHAR;
            end
          end
        end
        S_BG: begin
          if (w_tx_done) begin
            bus.TxStart_o <= 1'b1;
            bus.TxData_o  <= char_byte(w_cell[7:0]);
            r_state       <= S_CHAR;
          end
        end
`endif
        S_CHAR: begin
          if (w_tx_done) begin
            if (r_col == LAST_COL) begin
              r_col         <= '0;
              bus.TxStart_o <= 1'b1;
              bus.TxData_o  <= EOL_BYTE;
              r_state       <= S_EOL;
            end else begin
              r_col         <= r_col + 1'b1;
              bus.RamAddr_o <= bus.RamAddr_o + ADDR_WIDTH'(1);
              r_state       <= S_READ;
            end
          end
        end
        S_EOL: begin
          if (w_tx_done) begin
            if (r_row == LAST_ROW) begin
              r_row         <= '0;
              bus.RamAddr_o <= '0;
              bus.Busy_o    <= 1'b0;
              bus.Done_o    <= 1'b1;
              r_state       <= S_FINISH;
            end else begin
              r_row         <= r_row + 1'b1;
              bus.RamAddr_o <= bus.RamAddr_o + ADDR_WIDTH'(1);
              r_state       <= S_READ;
            end
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_dump_tx.sv
// tb/tb_text_dump_tx.sv - directed self-checking bench for text_dump_tx on a 4x2 screen
module tb_text_dump_tx;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  text_dump_tx_if #(.ADDR_WIDTH(4)) bus ();

  text_dump_tx #(
    .COLUMNS(4), .ROWS(2), .ADDR_WIDTH(4), .EOL_BYTE(8'h13)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  logic [15:0] mem [16];
  logic [7:0]  rx_q [$];
  int done_cnt = 0;
  int uart_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // RAM, UART (TxDone 5 cycles after TxStart) and byte/Done monitor
  always @(negedge Clock) begin
    bus.RamData_i = mem[bus.RamAddr_o];
    bus.TxDone_i = 1'b0;
    if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) bus.TxDone_i = 1'b1;
    end
    if (bus.TxStart_o === 1'b1) begin
      rx_q.push_back(bus.TxData_o);
      uart_cnt = 5;
    end
    if (bus.Done_o === 1'b1) done_cnt++;
  end

  task automatic fill_all(input logic [15:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic do_start();
    bus.Start_i = 1'b1;
    @(posedge Clock); #1;
    bus.Start_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge Clock); #1;
      if (bus.Done_o === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    n_cmp++; if (bus.Busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.Busy_o); end
    n_cmp++; if (bus.Done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.Done_o); end
    n_cmp++; if (bus.TxStart_o !== 1'b0) begin n_bad++; $display("FAIL reset_txstart: got %b want 0", bus.TxStart_o); end
    n_cmp++; if (bus.TxData_o !== 8'h00) begin n_bad++; $display("FAIL reset_txdata: got %h want 00", bus.TxData_o); end
    n_cmp++; if (bus.RamAddr_o !== 4'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.RamAddr_o); end
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_all_same();
    logic [7:0] exp [$];
    logic [7:0] got;
    bit ok;
`ifdef TEXT_DUMP_COLOR_EN
    exp = '{8'hF0, 8'h88, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`else
    exp = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h13, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`endif
    fill_all(16'h7041);
    rx_q.delete();
    done_cnt = 0;
    do_start();
    n_cmp++; if (bus.Busy_o !== 1'b1) begin n_bad++; $display("FAIL all_busy_n1: got %b want 1", bus.Busy_o); end
    n_cmp++; if (bus.RamAddr_o !== 4'h0) begin n_bad++; $display("FAIL all_addr_n1: got %h want 0", bus.RamAddr_o); end
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    n_cmp++; if (bus.TxStart_o !== 1'b1) begin n_bad++; $display("FAIL all_txstart_n3: got %b want 1", bus.TxStart_o); end
    n_cmp++; if (bus.TxData_o !== exp[0]) begin n_bad++; $display("FAIL all_txdata_n3: got %h want %h", bus.TxData_o, exp[0]); end
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL all_done_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.Busy_o !== 1'b0) begin n_bad++; $display("FAIL all_busy_at_done: got %b want 0", bus.Busy_o); end
    repeat (10) @(posedge Clock);
    #1;
    n_cmp++; if (bus.Busy_o !== 1'b0) begin n_bad++; $display("FAIL all_busy_after: got %b want 0", bus.Busy_o); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL all_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (rx_q.size() !== exp.size()) begin n_bad++; $display("FAIL all_len: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL all_byte[%0d]: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_color_change();
    logic [7:0] exp [$];
    logic [7:0] got;
    bit ok;
`ifdef TEXT_DUMP_COLOR_EN
    exp = '{8'hF0, 8'h88, 8'h41, 8'h41, 8'hA0, 8'h42, 8'hF0, 8'h41, 8'h13,
            8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`else
    exp = '{8'h41, 8'h41, 8'h42, 8'h41, 8'h13, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`endif
    fill_all(16'h7041);
    mem[2] = 16'h2042;
    rx_q.delete();
    done_cnt = 0;
    do_start();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL color_done_timeout: got %b want 1", ok); end
    repeat (4) @(posedge Clock);
    #1;
    n_cmp++; if (rx_q.size() !== exp.size()) begin n_bad++; $display("FAIL color_len: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL color_byte[%0d]: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_char_map();
    logic [7:0] exp [$];
    logic [7:0] got;
    bit ok;
`ifdef TEXT_DUMP_COLOR_EN
    exp = '{8'hF0, 8'h88, 8'h3F, 8'h01, 8'h41, 8'h41, 8'h13, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`else
    exp = '{8'h3F, 8'h01, 8'h41, 8'h41, 8'h13, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`endif
    fill_all(16'h7041);
    mem[0] = 16'h70C1;
    mem[1] = 16'h7001;
    rx_q.delete();
    done_cnt = 0;
    do_start();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL char_done_timeout: got %b want 1", ok); end
    repeat (4) @(posedge Clock);
    #1;
    n_cmp++; if (rx_q.size() !== exp.size()) begin n_bad++; $display("FAIL char_len: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL char_byte[%0d]: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int exp_len;
    bit ok;
`ifdef TEXT_DUMP_COLOR_EN
    exp_len = 12;
`else
    exp_len = 10;
`endif
    fill_all(16'h7041);
    rx_q.delete();
    done_cnt = 0;
    do_start();
    repeat (20) @(posedge Clock);
    #1;
    do_start();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ignore_done_timeout: got %b want 1", ok); end
    bus.Start_i = 1'b1;
    @(posedge Clock); #1;
    bus.Start_i = 1'b0;
    repeat (40) @(posedge Clock);
    #1;
    n_cmp++; if (bus.Busy_o !== 1'b0) begin n_bad++; $display("FAIL ignore_busy: got %b want 0", bus.Busy_o); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (rx_q.size() !== exp_len) begin n_bad++; $display("FAIL ignore_len: got %0d want %0d", rx_q.size(), exp_len); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [$];
    logic [7:0] got;
    int starts;
    bit ok;
`ifdef TEXT_DUMP_COLOR_EN
    exp = '{8'hF0, 8'h88, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`else
    exp = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h13, 8'h41, 8'h41, 8'h41, 8'h41, 8'h13};
`endif
    fill_all(16'h7041);
    rx_q.delete();
    done_cnt = 0;
    starts = 0;
    do_start();
    for (int i = 0; i < 500 && starts < 5; i++) begin
      @(posedge Clock); #1;
      if (bus.TxStart_o === 1'b1) starts++;
    end
    n_cmp++; if (starts !== 5) begin n_bad++; $display("FAIL rmid_fifth_start: got %0d want 5", starts); end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    n_cmp++; if (bus.Busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.Busy_o); end
    n_cmp++; if (bus.TxStart_o !== 1'b0) begin n_bad++; $display("FAIL rmid_txstart: got %b want 0", bus.TxStart_o); end
    n_cmp++; if (bus.TxData_o !== 8'h00) begin n_bad++; $display("FAIL rmid_txdata: got %h want 00", bus.TxData_o); end
    n_cmp++; if (bus.RamAddr_o !== 4'h0) begin n_bad++; $display("FAIL rmid_addr: got %h want 0", bus.RamAddr_o); end
    repeat (12) @(posedge Clock);
    #1;
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt); end
    n_cmp++; if (bus.Busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_idle: got %b want 0", bus.Busy_o); end
    rx_q.delete();
    do_start();
    n_cmp++; if (bus.RamAddr_o !== 4'h0) begin n_bad++; $display("FAIL rmid_restart_addr: got %h want 0", bus.RamAddr_o); end
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmid_done_timeout: got %b want 1", ok); end
    repeat (4) @(posedge Clock);
    #1;
    n_cmp++; if (rx_q.size() !== exp.size()) begin n_bad++; $display("FAIL rmid_len: got %0d want %0d", rx_q.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL rmid_byte[%0d]: got %h want %h", i, got, exp[i]); end
    end
  endtask

  initial begin
    bus.Start_i = 1'b0;
    bus.TxDone_i = 1'b0;
    bus.RamData_i = 16'h0000;
    fill_all(16'h7041);
    test_reset();
    test_all_same();
    test_color_change();
    test_char_map();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
